// File: rtl/trak_quad_decoder.sv
// Trackball receiver: synchronises the async dir/step lines and counts every step toggle into wrapping per-axis counters.
// Optional step-line glitch filter is enabled by defining TRAK_GLITCH_FILTER_EN.
module trak_quad_decoder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       trak_dir_x,
    input  logic       trak_clk_x,
    input  logic       trak_dir_y,
    input  logic       trak_clk_y,
    input  logic       flip,
    input  logic       clr_x,
    input  logic       clr_y,
    input  logic       rd,
    input  logic       rd_sel,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       step_x,
    output logic       step_y
);

    localparam int unsigned AXES = 2;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (CNT_W < 1 || CNT_W > 7) begin : g_bad_cnt
        $error("CNT_W must be 1..7");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
        $error("FILTER_CYCLES must be 1..15");
    end

    logic [AXES-1:0]        raw_clk;
    logic [AXES-1:0]        raw_dir;
    logic [SYNC_STAGES-1:0] clk_sync_q [AXES];
    logic [SYNC_STAGES-1:0] dir_sync_q [AXES];
    logic [AXES-1:0]        clk_s;
    logic [AXES-1:0]        dir_s;
    logic [AXES-1:0]        lvl;
    logic [AXES-1:0]        prev_q;
    logic [AXES-1:0]        edge_det;
    logic [AXES-1:0]        eff_dir;
    logic [AXES-1:0]        clr_vec;
    logic [AXES-1:0]        step_q, step_d;
    logic [AXES-1:0]        last_dir_q, last_dir_d;
    logic [CNT_W-1:0]       cnt_q [AXES];
    logic [CNT_W-1:0]       cnt_d [AXES];
    logic [7:0]             rd_word;
    logic [7:0]             rd_data_q, rd_data_d;
    logic                   rd_valid_q;

    assign raw_clk = {trak_clk_y, trak_clk_x};
    assign raw_dir = {trak_dir_y, trak_dir_x};
    assign clr_vec = {clr_y, clr_x};

    // Dir and clk share the same chain depth so a step sees the dir set with it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int unsigned a = 0; a < AXES; a++) begin
                clk_sync_q[a] <= '0;
                dir_sync_q[a] <= '0;
            end
        end else begin
            for (int unsigned a = 0; a < AXES; a++) begin
                clk_sync_q[a] <= {clk_sync_q[a][SYNC_STAGES-2:0], raw_clk[a]};
                dir_sync_q[a] <= {dir_sync_q[a][SYNC_STAGES-2:0], raw_dir[a]};
            end
        end
    end

    always_comb begin
        clk_s = '0;
        dir_s = '0;
        for (int unsigned a = 0; a < AXES; a++) begin
            clk_s[a] = clk_sync_q[a][SYNC_STAGES-1];
            dir_s[a] = dir_sync_q[a][SYNC_STAGES-1];
        end
    end

`ifdef TRAK_GLITCH_FILTER_EN
    localparam int unsigned STAB_W = 4;

    logic [AXES-1:0]   flt_q, flt_d;
    logic [STAB_W-1:0] stab_q [AXES];
    logic [STAB_W-1:0] stab_d [AXES];

    // A new clk level is adopted only after FILTER_CYCLES consecutive cycles at that level.
    always_comb begin
        flt_d = flt_q;
        for (int unsigned a = 0; a < AXES; a++) begin
            stab_d[a] = '0;
            if (clk_s[a] != flt_q[a]) begin
                if (stab_q[a] == STAB_W'(FILTER_CYCLES - 1)) begin
                    flt_d[a] = clk_s[a];
                end else begin
                    stab_d[a] = stab_q[a] + STAB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            flt_q <= '0;
            for (int unsigned a = 0; a < AXES; a++) begin
                stab_q[a] <= '0;
            end
        end else begin
            flt_q <= flt_d;
            for (int unsigned a = 0; a < AXES; a++) begin
                stab_q[a] <= stab_d[a];
            end
        end
    end

    assign lvl = flt_q;
`else
    assign lvl = clk_s;
`endif

    assign edge_det = lvl ^ prev_q;
    assign eff_dir  = dir_s ^ {AXES{flip}};

    // Clear beats a simultaneous step; the step is dropped without a pulse.
    always_comb begin
        step_d     = '0;
        last_dir_d = last_dir_q;
        for (int unsigned a = 0; a < AXES; a++) begin
            cnt_d[a] = cnt_q[a];
            if (clr_vec[a]) begin
                cnt_d[a] = '0;
            end else if (edge_det[a]) begin
                step_d[a]     = 1'b1;
                last_dir_d[a] = eff_dir[a];
                cnt_d[a]      = eff_dir[a] ? cnt_q[a] + CNT_W'(1) : cnt_q[a] - CNT_W'(1);
            end
        end
    end

    // Read port samples the pre-update counter so a coincident step is not visible yet.
    always_comb begin
        rd_word    = 8'(cnt_q[rd_sel]);
        rd_word[7] = last_dir_q[rd_sel];
        rd_data_d  = rd ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            step_q     <= '0;
            last_dir_q <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            for (int unsigned a = 0; a < AXES; a++) begin
                cnt_q[a] <= '0;
            end
        end else begin
            prev_q     <= lvl;
            step_q     <= step_d;
            last_dir_q <= last_dir_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd;
            for (int unsigned a = 0; a < AXES; a++) begin
                cnt_q[a] <= cnt_d[a];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign step_x   = step_q[0];
    assign step_y   = step_q[1];

endmodule

// File: doc/trak_quad_decoder.md
Name: trak_quad_decoder

Overview:
- Receive-side counterpart of the mouse-to-trackball encoder.
- Takes the per-axis "direction + toggle-clock" trackball lines, which are asynchronous to clk_sys.
- Synchronises them, detects every toggle, and accumulates signed motion into wrapping per-axis counters.
- The game CPU reads the counters through a registered read port, as the arcade trackball counter chips did. Sits between the trackball/encoder outputs and the CPU input mux.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each raw input (2..4).
- CNT_W, 4, width of each axis counter (1..7).
- FILTER_CYCLES, 3, stable cycles required by the glitch filter (used only with the optional feature, 1..15).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- trak_dir_x  in  1  X direction line, raw/async; 1 = positive motion.
- trak_clk_x  in  1  X step line, raw/async; each transition (either edge) = one step.
- trak_dir_y  in  1  Y direction line, raw/async.
- trak_clk_y  in  1  Y step line, raw/async.
- flip  in  1  cocktail flip; inverts both direction lines' meaning.
- clr_x  in  1  synchronous clear of the X counter.
- clr_y  in  1  synchronous clear of the Y counter.
- rd  in  1  read strobe, one cycle.
- rd_sel  in  1  0 = X, 1 = Y; sampled with rd.
- rd_data  out  8  [7] = last direction of the selected axis; [6:CNT_W] = 0; [CNT_W-1:0] = counter.
- rd_valid  out  1  one-cycle pulse, rd_data updated.
- step_x  out  1  one-cycle pulse per accepted X step.
- step_y  out  1  one-cycle pulse per accepted Y step.

Behaviour:
- Reset (asynchronous):
  - All synchroniser flops, counters and last-direction bits go to 0.
  - The previous-clock registers also load 0, so a raw clk line held at 1 during reset produces exactly one step after release.
  - rd_data = 8'h00; rd_valid = 0; step_x = step_y = 0.
- Synchronisation:
  - Each raw line passes through SYNC_STAGES flops.
  - The dir sample used for a step is the synchronised dir in the same cycle the clk edge is detected.
  - The encoder sets dir and toggles clk together. Equal SYNC_STAGES on both lines therefore keeps them aligned.
- Edge detect: step when synchronised clk != registered previous value. Previous value updates every cycle.
- Per axis, in the cycle after an edge is detected (2 stages plus detect gives raw-to-counter latency of SYNC_STAGES+1 cycles):
  - eff_dir = dir_sync XOR flip.
  - eff_dir = 1: counter <= counter + 1, modulo 2^CNT_W (all-ones wraps to 0).
  - eff_dir = 0: counter <= counter - 1 (0 wraps to all-ones).
  - last_dir <= eff_dir; step_x/step_y pulses in that same cycle.
- Clear:
  - clr_* and a step in the same cycle: clear wins, the step is discarded, and no step pulse is issued.
  - last_dir keeps its value on clear.
- Read:
  - On rd, rd_data is registered from the selected axis one cycle later, together with a rd_valid pulse.
  - rd_data holds its value until the next rd.
  - rd in the same cycle as a step on the selected axis returns the pre-step value.
  - Back-to-back rd is allowed every cycle.
- Axes are fully independent; simultaneous X and Y steps are both counted.
- flip changes take effect on the next detected step only. Existing counts are not altered.

Optional Feature:
- Macro: TRAK_GLITCH_FILTER_EN.
- When defined:
  - Each synchronised clk line feeds a per-axis stability counter.
  - A new level is accepted, and an edge generated, only after it has been stable for FILTER_CYCLES consecutive cycles.
  - Pulses shorter than FILTER_CYCLES are ignored.
  - Latency grows by FILTER_CYCLES.
- When undefined: no filter logic; every synchronised transition is a step.

Test Plan:
- Count up: hold trak_dir_x=1 and toggle trak_clk_x 5 times, 10 cycles apart, then rd with rd_sel=0. Required: step_x pulses 5 times; rd_data = 8'h85 (dir=1, count 5), with rd_valid exactly one cycle after rd.
- Wrap down: after reset, trak_dir_y=0 and 3 toggles of trak_clk_y, then rd with rd_sel=1. Required: rd_data = 8'h0D (count 4'hD, dir=0).
- Flip: flip=1, trak_dir_x=1, 2 toggles. Required: X count = 4'hE, rd_data[7] = 0. Then flip=0 and 2 toggles: count returns to 4'h0, rd_data[7] = 1.
- Clear priority: clr_x asserted in the exact cycle a step is detected, with count 7. Required: count = 0 the next cycle and step_x stays low.
- Reset mid-operation: assert reset asynchronously between clock edges while toggling. Required: all outputs 0 immediately. With trak_clk_x held at 1 through release, exactly one step is counted after release.
- Filter (with TRAK_GLITCH_FILTER_EN, FILTER_CYCLES=3): a 2-cycle pulse on trak_clk_x gives no step. A level held 3 cycles gives exactly one step.
